maquina_ctrl_param: RTL and testbench

//  Parametrised control FSM for the interconnect device. Latches the MF/VC/D high/low FIFO thresholds during INIT,

---
 rtl/maquina_pkg.sv | 30 +++
 rtl/maquina_ctrl_param_if.sv | 71 +++++++
 rtl/maquina_hold_cnt.sv | 41 ++++
 rtl/maquina_ctrl_param.sv | 185 ++++++++++++++++++
 tb/tb_maquina_ctrl_param.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/maquina_pkg.sv
// ============================================================================
//  Module      : maquina_pkg
//  Description : Shared definitions for the maquina_ctrl_param control FSM:
//                one-hot state encodings and reset-time threshold defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maquina_pkg;

  // One-hot state encoding; any other pattern is treated as illegal.
  typedef logic [4:0] state_t;

  localparam state_t ST_RESET  = 5'd1;
  localparam state_t ST_INIT   = 5'd2;
  localparam state_t ST_IDLE   = 5'd4;
  localparam state_t ST_ACTIVE = 5'd8;
  localparam state_t ST_ERROR  = 5'd16;

  // Threshold values restored on reset.
  localparam int DFLT_MF_ALTO = 3;
  localparam int DFLT_MF_BAJO = 1;
  localparam int DFLT_VC_ALTO = 15;
  localparam int DFLT_VC_BAJO = 1;
  localparam int DFLT_D_ALTO  = 3;
  localparam int DFLT_D_BAJO  = 1;

endpackage

`default_nettype wire

// File: rtl/maquina_ctrl_param_if.sv
// ============================================================================
//  Module      : maquina_ctrl_param_if
//  Description : Control/status bundle between the FIFO bank manager (master)
//                and the maquina_ctrl_param FSM (slave).
//                Optional macro: MAQUINA_ERR_CNT_EN adds error_count_out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface maquina_ctrl_param_if #(
  parameter int NUM_FIFOS = 5,
  parameter int UMB_W     = 5
);

  logic                 init;
  logic                 err_clr;
  logic [UMB_W-1:0]     Umbral_MF_alto;
  logic [UMB_W-1:0]     Umbral_MF_bajo;
  logic [UMB_W-1:0]     Umbral_VC_alto;
  logic [UMB_W-1:0]     Umbral_VC_bajo;
  logic [UMB_W-1:0]     Umbral_D_alto;
  logic [UMB_W-1:0]     Umbral_D_bajo;
  logic [NUM_FIFOS-1:0] FIFO_empties;
  logic [NUM_FIFOS-1:0] FIFO_errors;

  logic [UMB_W-1:0]     Umbral_MF_alto_interno;
  logic [UMB_W-1:0]     Umbral_MF_bajo_interno;
  logic [UMB_W-1:0]     Umbral_VC_alto_interno;
  logic [UMB_W-1:0]     Umbral_VC_bajo_interno;
  logic [UMB_W-1:0]     Umbral_D_alto_interno;
  logic [UMB_W-1:0]     Umbral_D_bajo_interno;
  logic                 cfg_invalid_out;
  logic                 error_out;
  logic                 active_out;
  logic                 idle_out;
  logic [NUM_FIFOS-1:0] errors_out;
`ifdef MAQUINA_ERR_CNT_EN
  logic [7:0]           error_count_out;
`endif

  modport master (
`ifdef MAQUINA_ERR_CNT_EN
    input  error_count_out,
`endif
    output init, err_clr,
    output Umbral_MF_alto, Umbral_MF_bajo, Umbral_VC_alto, Umbral_VC_bajo,
    output Umbral_D_alto, Umbral_D_bajo,
    output FIFO_empties, FIFO_errors,
    input  Umbral_MF_alto_interno, Umbral_MF_bajo_interno,
    input  Umbral_VC_alto_interno, Umbral_VC_bajo_interno,
    input  Umbral_D_alto_interno, Umbral_D_bajo_interno,
    input  cfg_invalid_out, error_out, active_out, idle_out, errors_out
  );

  modport slave (
`ifdef MAQUINA_ERR_CNT_EN
    output error_count_out,
`endif
    input  init, err_clr,
    input  Umbral_MF_alto, Umbral_MF_bajo, Umbral_VC_alto, Umbral_VC_bajo,
    input  Umbral_D_alto, Umbral_D_bajo,
    input  FIFO_empties, FIFO_errors,
    output Umbral_MF_alto_interno, Umbral_MF_bajo_interno,
    output Umbral_VC_alto_interno, Umbral_VC_bajo_interno,
    output Umbral_D_alto_interno, Umbral_D_bajo_interno,
    output cfg_invalid_out, error_out, active_out, idle_out, errors_out
  );

endinterface

`default_nettype wire

// File: rtl/maquina_hold_cnt.sv
// ============================================================================
//  Module      : maquina_hold_cnt
//  Description : Saturating consecutive-cycle counter. done is asserted in the
//                cycle where inc completes HOLD consecutive increments.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maquina_hold_cnt #(
  parameter int HOLD = 2
) (
  input  wire clk,
  input  wire reset,
  input  wire inc,
  input  wire clr,
  output wire done
);

  localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  // Current cycle counts toward the run, so done fires on the HOLD-th inc.
  assign done = inc && (cnt >= CNT_LAST);

  // Count consecutive inc cycles; clear wins over inc; saturate at HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/maquina_ctrl_param.sv
// ============================================================================
//  Module      : maquina_ctrl_param
//  Description : Parametrised FIFO-bank control FSM. Latches validated MF/VC/D
//                thresholds during INIT, then tracks the bank as IDLE/ACTIVE/
//                ERROR with idle hysteresis and sticky error capture.
//                Optional macro: MAQUINA_ERR_CNT_EN adds a saturating count of
//                ERROR entries on error_count_out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maquina_ctrl_param
  import maquina_pkg::*;
#(
  parameter int NUM_FIFOS   = 5,
  parameter int UMB_W       = 5,
  parameter int IDLE_HOLD   = 2,
  parameter int DEF_MF_ALTO = DFLT_MF_ALTO,
  parameter int DEF_MF_BAJO = DFLT_MF_BAJO,
  parameter int DEF_VC_ALTO = DFLT_VC_ALTO,
  parameter int DEF_VC_BAJO = DFLT_VC_BAJO,
  parameter int DEF_D_ALTO  = DFLT_D_ALTO,
  parameter int DEF_D_BAJO  = DFLT_D_BAJO
) (
  input wire clk,
  input wire reset,
  maquina_ctrl_param_if.slave bus
);

  state_t state;
  state_t next_state;

  logic [UMB_W-1:0] mf_alto, mf_bajo, vc_alto, vc_bajo, d_alto, d_bajo;
  logic             cfg_invalid;
  logic             error_flag, active_flag, idle_flag;
  logic [NUM_FIFOS-1:0] errors_q;
  logic [NUM_FIFOS-1:0] sticky;

  logic                 cfg_ok;
  logic                 all_empty;
  logic                 any_err;
  logic                 hold_inc;
  logic                 hold_clr;
  logic                 hold_done;

  logic                 load_en;
  logic                 cfg_invalid_d;
  logic                 error_d, active_d, idle_d;
  logic [NUM_FIFOS-1:0] errors_d;
  logic [NUM_FIFOS-1:0] sticky_d;

  assign cfg_ok    = (bus.Umbral_MF_bajo <= bus.Umbral_MF_alto) &&
                     (bus.Umbral_VC_bajo <= bus.Umbral_VC_alto) &&
                     (bus.Umbral_D_bajo  <= bus.Umbral_D_alto);
  assign all_empty = &bus.FIFO_empties;
  assign any_err   = |bus.FIFO_errors;

  // Hysteresis only runs while ACTIVE with every FIFO empty; any break clears it.
  assign hold_inc  = (state == ST_ACTIVE) && all_empty;
  assign hold_clr  = !hold_inc || (next_state != ST_ACTIVE);

  maquina_hold_cnt #(
    .HOLD (IDLE_HOLD)
  ) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hold_inc),
    .clr   (hold_clr),
    .done  (hold_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RESET;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; init has top priority except inside ERROR.
  always_comb begin
    next_state = state;
    case (state)
      ST_RESET:  next_state = ST_INIT;
      ST_INIT:   next_state = bus.init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (bus.init)        next_state = ST_INIT;
        else if (any_err)    next_state = ST_ERROR;
        else if (!all_empty) next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init)        next_state = ST_INIT;
        else if (any_err)    next_state = ST_ERROR;
        else if (hold_done)  next_state = ST_IDLE;
      end
      ST_ERROR: begin
        if (bus.err_clr && !any_err) next_state = ST_IDLE;
      end
      default:   next_state = ST_RESET;
    endcase
  end

  // Next values of the registered outputs, sticky capture and config load.
  always_comb begin
    load_en       = (state == ST_INIT) && cfg_ok;
    cfg_invalid_d = (state == ST_INIT) ? !cfg_ok : cfg_invalid;
    idle_d        = (state == ST_IDLE);
    active_d      = (state == ST_ACTIVE);
    error_d       = (state == ST_ERROR);
    errors_d      = '0;
    sticky_d      = '0;
    if (state == ST_ERROR) begin
      errors_d = sticky | bus.FIFO_errors;
      if (next_state == ST_ERROR) begin
        sticky_d = sticky | bus.FIFO_errors;
      end
    end else if (next_state == ST_ERROR) begin
      sticky_d = bus.FIFO_errors;
    end
  end

  // Thresholds, flags and sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mf_alto     <= UMB_W'(DEF_MF_ALTO);
      mf_bajo     <= UMB_W'(DEF_MF_BAJO);
      vc_alto     <= UMB_W'(DEF_VC_ALTO);
      vc_bajo     <= UMB_W'(DEF_VC_BAJO);
      d_alto      <= UMB_W'(DEF_D_ALTO);
      d_bajo      <= UMB_W'(DEF_D_BAJO);
      cfg_invalid <= 1'b0;
      idle_flag   <= 1'b0;
      active_flag <= 1'b0;
      error_flag  <= 1'b0;
      errors_q    <= '0;
      sticky      <= '0;
    end else begin
      if (load_en) begin
        mf_alto <= bus.Umbral_MF_alto;
        mf_bajo <= bus.Umbral_MF_bajo;
        vc_alto <= bus.Umbral_VC_alto;
        vc_bajo <= bus.Umbral_VC_bajo;
        d_alto  <= bus.Umbral_D_alto;
        d_bajo  <= bus.Umbral_D_bajo;
      end
      cfg_invalid <= cfg_invalid_d;
      idle_flag   <= idle_d;
      active_flag <= active_d;
      error_flag  <= error_d;
      errors_q    <= errors_d;
      sticky      <= sticky_d;
    end
  end

`ifdef MAQUINA_ERR_CNT_EN
  logic [7:0] err_cnt;

  // Count transitions into ERROR, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if ((state != ST_ERROR) && (next_state == ST_ERROR) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.error_count_out = err_cnt;
`endif

  assign bus.Umbral_MF_alto_interno = mf_alto;
  assign bus.Umbral_MF_bajo_interno = mf_bajo;
  assign bus.Umbral_VC_alto_interno = vc_alto;
  assign bus.Umbral_VC_bajo_interno = vc_bajo;
  assign bus.Umbral_D_alto_interno  = d_alto;
  assign bus.Umbral_D_bajo_interno  = d_bajo;
  assign bus.cfg_invalid_out        = cfg_invalid;
  assign bus.error_out              = error_flag;
  assign bus.active_out             = active_flag;
  assign bus.idle_out               = idle_flag;
  assign bus.errors_out             = errors_q;

endmodule

`default_nettype wire

// File: tb/tb_maquina_ctrl_param.sv
// ============================================================================
//  Module      : tb_maquina_ctrl_param
//  Description : Directed scoreboard bench for maquina_ctrl_param
//                (NUM_FIFOS=5, UMB_W=5, IDLE_HOLD=2). Honours MAQUINA_ERR_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maquina_ctrl_param;

  logic clk;
  logic reset;

  maquina_ctrl_param_if #(.NUM_FIFOS(5), .UMB_W(5)) bus ();

  maquina_ctrl_param #(
    .NUM_FIFOS (5),
    .UMB_W     (5),
    .IDLE_HOLD (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic [4:0] mfa, mfb, vca, vcb, da, db;
    logic     cfg, err, act, idl;
    logic [4:0] eo;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Hand-maintained expected thresholds, config flag and error-entry count.
  logic [4:0] e_mfa, e_mfb, e_vca, e_vcb, e_da, e_db;
  logic       e_cfg;
  logic [7:0] e_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic err, input logic act,
                            input logic idl, input logic [4:0] eo);
    exp_t e;
    e.name = name;
    e.mfa = e_mfa; e.mfb = e_mfb; e.vca = e_vca; e.vcb = e_vcb; e.da = e_da; e.db = e_db;
    e.cfg = e_cfg; e.err = err; e.act = act; e.idl = idl; e.eo = eo; e.cnt = e_cnt;
    q.push_back(e);
  endtask

  task automatic set_thr(input logic [4:0] mfa, input logic [4:0] mfb, input logic [4:0] vca,
                         input logic [4:0] vcb, input logic [4:0] da, input logic [4:0] db);
    bus.Umbral_MF_alto = mfa; bus.Umbral_MF_bajo = mfb;
    bus.Umbral_VC_alto = vca; bus.Umbral_VC_bajo = vcb;
    bus.Umbral_D_alto  = da;  bus.Umbral_D_bajo  = db;
  endtask

  task automatic exp_thr(input logic [4:0] mfa, input logic [4:0] mfb, input logic [4:0] vca,
                         input logic [4:0] vcb, input logic [4:0] da, input logic [4:0] db);
    e_mfa = mfa; e_mfb = mfb; e_vca = vca; e_vcb = vcb; e_da = da; e_db = db;
  endtask

  // Monitor: compare the DUT output snapshot mid-cycle against each queued expectation.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic ok;
      e = q.pop_front();
      ok = (bus.Umbral_MF_alto_interno === e.mfa) && (bus.Umbral_MF_bajo_interno === e.mfb) &&
           (bus.Umbral_VC_alto_interno === e.vca) && (bus.Umbral_VC_bajo_interno === e.vcb) &&
           (bus.Umbral_D_alto_interno  === e.da)  && (bus.Umbral_D_bajo_interno  === e.db)  &&
           (bus.cfg_invalid_out === e.cfg) && (bus.error_out === e.err) &&
           (bus.active_out === e.act) && (bus.idle_out === e.idl) && (bus.errors_out === e.eo);
`ifdef MAQUINA_ERR_CNT_EN
      ok = ok && (bus.error_count_out === e.cnt);
`endif
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s: got thr=%0d/%0d,%0d/%0d,%0d/%0d cfg=%b err=%b act=%b idl=%b eo=%b cnt=%0d want thr=%0d/%0d,%0d/%0d,%0d/%0d cfg=%b err=%b act=%b idl=%b eo=%b cnt=%0d",
                 e.name,
                 bus.Umbral_MF_alto_interno, bus.Umbral_MF_bajo_interno,
                 bus.Umbral_VC_alto_interno, bus.Umbral_VC_bajo_interno,
                 bus.Umbral_D_alto_interno, bus.Umbral_D_bajo_interno,
                 bus.cfg_invalid_out, bus.error_out, bus.active_out, bus.idle_out, bus.errors_out,
`ifdef MAQUINA_ERR_CNT_EN
                 bus.error_count_out,
`else
                 e.cnt,
`endif
                 e.mfa, e.mfb, e.vca, e.vcb, e.da, e.db,
                 e.cfg, e.err, e.act, e.idl, e.eo, e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.init = 1'b0;
    bus.err_clr = 1'b0;
    set_thr(5'd3, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1);
    bus.FIFO_empties = 5'b11111;
    bus.FIFO_errors  = 5'b00000;
    exp_thr(5'd3, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1);
    e_cfg = 1'b0;
    e_cnt = 8'd0;

    // 1. reset, release, walk RESET -> INIT -> IDLE
    tick(); expect_out("rst_c1", 0, 0, 0, 5'b0);
    tick(); expect_out("rst_c2", 0, 0, 0, 5'b0);
    reset = 1'b0;
    tick(); expect_out("rel_c1_reset", 0, 0, 0, 5'b0);
    tick(); expect_out("rel_c2_init", 0, 0, 0, 5'b0);
    tick(); expect_out("rel_c3_idle", 0, 0, 1, 5'b0);

    // 2a. valid INIT load
    bus.init = 1'b1;
    set_thr(5'd10, 5'd4, 5'd20, 5'd2, 5'd6, 5'd5);
    tick(); expect_out("init_enter", 0, 0, 1, 5'b0);
    tick(); exp_thr(5'd10, 5'd4, 5'd20, 5'd2, 5'd6, 5'd5);
    expect_out("init_load", 0, 0, 0, 5'b0);
    bus.init = 1'b0;
    tick(); expect_out("init_exit", 0, 0, 0, 5'b0);
    tick(); expect_out("init_idle", 0, 0, 1, 5'b0);

    // 2b. rejected INIT load (MF bajo > alto)
    bus.init = 1'b1;
    set_thr(5'd10, 5'd12, 5'd20, 5'd2, 5'd6, 5'd5);
    tick(); expect_out("bad_enter", 0, 0, 1, 5'b0);
    tick(); e_cfg = 1'b1;
    expect_out("bad_reject", 0, 0, 0, 5'b0);
    bus.init = 1'b0;
    tick(); expect_out("bad_exit", 0, 0, 0, 5'b0);
    bus.Umbral_MF_bajo = 5'd4;
    tick(); expect_out("bad_hold", 0, 0, 1, 5'b0);

    // 3. idle hysteresis
    bus.FIFO_empties = 5'b11011;
    tick(); expect_out("act_enter", 0, 0, 1, 5'b0);
    bus.FIFO_empties = 5'b11111;
    tick(); expect_out("act_empty1", 0, 1, 0, 5'b0);
    bus.FIFO_empties = 5'b11110;
    tick(); expect_out("act_break", 0, 1, 0, 5'b0);
    bus.FIFO_empties = 5'b11111;
    tick(); expect_out("act_empty_a", 0, 1, 0, 5'b0);
    tick(); expect_out("act_empty_b", 0, 1, 0, 5'b0);
    tick(); expect_out("act_to_idle", 0, 0, 1, 5'b0);

    // 4. sticky errors and clear
    bus.FIFO_empties = 5'b11011;
    tick(); expect_out("act2_enter", 0, 0, 1, 5'b0);
    bus.FIFO_errors = 5'b00100;
    tick(); e_cnt = 8'd1;
    expect_out("err_enter", 0, 1, 0, 5'b0);
    bus.FIFO_errors = 5'b00001;
    tick(); expect_out("err_sticky", 1, 0, 0, 5'b00101);
    bus.err_clr = 1'b1;
    tick(); expect_out("err_clr_refused", 1, 0, 0, 5'b00101);
    bus.FIFO_errors = 5'b00000;
    tick(); expect_out("err_clr_ok", 1, 0, 0, 5'b00101);
    bus.err_clr = 1'b0;
    tick(); expect_out("err_left", 0, 0, 1, 5'b00000);

    // 5a. init beats errors in ACTIVE (DUT is in ACTIVE now)
    bus.init = 1'b1;
    bus.FIFO_errors = 5'b00010;
    tick(); expect_out("init_vs_err", 0, 1, 0, 5'b0);
    tick(); e_cfg = 1'b0;
    expect_out("init_won", 0, 0, 0, 5'b0);
    bus.init = 1'b0;
    bus.FIFO_errors = 5'b00000;
    tick(); expect_out("init2_exit", 0, 0, 0, 5'b0);
    tick(); expect_out("idle2_to_act", 0, 0, 1, 5'b0);

    // 5b. reset while in ERROR
    bus.FIFO_errors = 5'b00001;
    tick(); e_cnt = 8'd2;
    expect_out("err2_enter", 0, 1, 0, 5'b0);
    tick(); expect_out("err2_in", 1, 0, 0, 5'b00001);
    reset = 1'b1;
    tick(); exp_thr(5'd3, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1);
    e_cfg = 1'b0; e_cnt = 8'd0;
    expect_out("err_reset", 0, 0, 0, 5'b0);
    bus.FIFO_errors = 5'b00000;
    bus.FIFO_empties = 5'b11111;
    set_thr(5'd3, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1);
    tick(); expect_out("err_reset_c2", 0, 0, 0, 5'b0);

`ifdef MAQUINA_ERR_CNT_EN
    // 6. saturating ERROR entry count
    reset = 1'b0;
    tick(); tick();
    for (int i = 0; i < 300; i++) begin
      bus.FIFO_errors = 5'b00001;
      tick();
      bus.FIFO_errors = 5'b00000;
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      if (i == 9)   expect_out("cnt_10", 1, 0, 0, 5'b00001);
    end
    tick(); expect_out("cnt_sat", 0, 0, 1, 5'b0);
    reset = 1'b1;
    tick(); e_cnt = 8'd0;
    expect_out("cnt_reset", 0, 0, 0, 5'b0);
`endif

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
